// File: rtl/fwd_pkg.sv
// Shared types and select codes for the EXE forwarding / hazard unit.
package fwd_pkg;

  localparam int ADDR_W = 5;

  localparam logic [1:0] SEL_IDEX  = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              usesRs;
    logic              usesRt;
    logic [ADDR_W-1:0] dest;
    logic              regWrite;
    logic              memRead;
  } exeRec_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic              regWrite;
  } destRec_t;

endpackage

// File: rtl/fwd_select.sv
// Operand source select for one EXE operand.
module fwd_select
  import fwd_pkg::*;
(
  input  logic              exeValid,
  input  logic              uses,
  input  logic [ADDR_W-1:0] srcAddr,
  input  destRec_t          memRec,
  input  destRec_t          wbRec,
  output logic [1:0]        sel
);

  logic memHit;
  logic wbHit;

  assign memHit = exeValid & uses & memRec.valid & memRec.regWrite
                & (memRec.dest != REG_ZERO)
                & (memRec.dest == srcAddr);

  assign wbHit = exeValid & uses & wbRec.valid & wbRec.regWrite
               & (wbRec.dest != REG_ZERO)
               & (wbRec.dest == srcAddr);

  // Younger producer in MEM takes priority over WB.
  always_comb begin
    sel = SEL_IDEX;
    if (memHit) begin
      sel = SEL_EXMEM;
    end else if (wbHit) begin
      sel = SEL_MEMWB;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding select and load-use stall unit beside the ID/EXE register.
// Optional HI/LO interlock enabled with `define HILO_INTERLOCK_EN.
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W   = ADDR_W,
  parameter int MULT_LATENCY = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  Freeze_IN,
  input  logic                  ID_Valid_IN,
  input  logic [REG_ADDR_W-1:0] ID_RsAddr_IN,
  input  logic [REG_ADDR_W-1:0] ID_RtAddr_IN,
  input  logic                  ID_UsesRs_IN,
  input  logic                  ID_UsesRt_IN,
  input  logic [REG_ADDR_W-1:0] ID_DestAddr_IN,
  input  logic                  ID_RegWrite_IN,
  input  logic                  ID_MemRead_IN,
  input  logic                  ID_IsMultDiv_IN,
  input  logic                  ID_ReadsHiLo_IN,
  output logic [1:0]            aSelect_OUT,
  output logic [1:0]            bSelect_OUT,
  output logic                  Stall_OUT
);

  exeRec_t  exeQ;
  exeRec_t  idRec;
  destRec_t memQ;
  destRec_t wbQ;

  logic rsHit;
  logic rtHit;
  logic loadUse;
  logic hiloStall;

  assign idRec = '{
    valid:    ID_Valid_IN,
    rs:       ID_RsAddr_IN,
    rt:       ID_RtAddr_IN,
    usesRs:   ID_UsesRs_IN,
    usesRt:   ID_UsesRt_IN,
    dest:     ID_DestAddr_IN,
    regWrite: ID_RegWrite_IN,
    memRead:  ID_MemRead_IN
  };

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      exeQ <= '0;
      memQ <= '0;
      wbQ  <= '0;
    end else if (!Freeze_IN) begin
      wbQ  <= memQ;
      memQ <= '{valid: exeQ.valid, dest: exeQ.dest,
                regWrite: exeQ.regWrite};
      exeQ <= Stall_OUT ? '0 : idRec;
    end
  end

  fwd_select uSelA (
    .exeValid (exeQ.valid),
    .uses     (exeQ.usesRs),
    .srcAddr  (exeQ.rs),
    .memRec   (memQ),
    .wbRec    (wbQ),
    .sel      (aSelect_OUT)
  );

  fwd_select uSelB (
    .exeValid (exeQ.valid),
    .uses     (exeQ.usesRt),
    .srcAddr  (exeQ.rt),
    .memRec   (memQ),
    .wbRec    (wbQ),
    .sel      (bSelect_OUT)
  );

  assign rsHit = ID_UsesRs_IN & (ID_RsAddr_IN == exeQ.dest);
  assign rtHit = ID_UsesRt_IN & (ID_RtAddr_IN == exeQ.dest);

  assign loadUse = ID_Valid_IN & exeQ.valid & exeQ.memRead
                 & exeQ.regWrite & (exeQ.dest != REG_ZERO)
                 & (rsHit | rtHit);

`ifdef HILO_INTERLOCK_EN
  localparam logic [3:0] HILO_LOAD = 4'(MULT_LATENCY - 1);

  logic [3:0] hiloCnt;

  // Reload only when the mult/div actually enters EXE.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      hiloCnt <= '0;
    end else if (!Freeze_IN) begin
      if (!Stall_OUT && ID_Valid_IN && ID_IsMultDiv_IN) begin
        hiloCnt <= HILO_LOAD;
      end else if (hiloCnt != 4'd0) begin
        hiloCnt <= hiloCnt - 4'd1;
      end
    end
  end

  assign hiloStall = (hiloCnt != 4'd0) & ID_Valid_IN
                   & ID_ReadsHiLo_IN;
`else
  logic unusedHiLo;

  assign unusedHiLo = ^{ID_IsMultDiv_IN, ID_ReadsHiLo_IN,
                        MULT_LATENCY[0]};
  assign hiloStall  = 1'b0;
`endif

  always_comb begin
    Stall_OUT = loadUse | hiloStall;
  end

endmodule
